// File: rtl/gf2k_seq_alu_if.sv
// Operand/result bundle for gf2k_seq_alu.
// The master drives operands; the slave returns busy and the result strobe.
interface gf2k_seq_alu_if #(
    parameter int unsigned DEG = 4
);
    logic           in_valid;
    logic [1:0]     MODE;
    logic [DEG:0]   POLY;
    logic [DEG-1:0] IN1;
    logic [DEG-1:0] IN2;
    logic           busy;
    logic           out_valid;
    logic [DEG-1:0] RESULT;
    logic           DIV0;

    modport master (
        output in_valid, MODE, POLY, IN1, IN2,
        input  busy, out_valid, RESULT, DIV0
    );

    modport slave (
        input  in_valid, MODE, POLY, IN1, IN2,
        output busy, out_valid, RESULT, DIV0
    );
endinterface

// File: rtl/gf2k_seq_alu.sv
// Sequential GF(2^DEG) ALU: ADD in one cycle; MUL, SQR and DIV on a shared bit-serial multiplier.
// DIV uses Fermat inversion B^(2^DEG-2) followed by a final multiply by A.
module gf2k_seq_alu #(
    parameter int unsigned DEG = 4
) (
    input logic            clk,
    input logic            rst_n,
    gf2k_seq_alu_if.slave  bus
);
    localparam int unsigned StepW   = $clog2(DEG);
    localparam int unsigned NMulDiv = 2 * DEG - 2;
    localparam int unsigned MulW    = $clog2(NMulDiv);

    localparam logic [1:0] ModeAdd = 2'd0;
    localparam logic [1:0] ModeDiv = 2'd2;
    localparam logic [1:0] ModeSqr = 2'd3;

    typedef enum logic [0:0] {StIdle, StMult} state_e;

    state_e         st_q, st_d;
    logic [1:0]     mode_q, mode_d;
    logic [DEG-1:0] poly_q, poly_d;
    logic [DEG-1:0] a_q, a_d;
    logic [DEG-1:0] b_q, b_d;
    logic [DEG-1:0] r_q, r_d;
    logic [DEG-1:0] acc_q, acc_d;
    logic [StepW-1:0] step_q, step_d;
    logic [MulW-1:0]  mul_q, mul_d;
    logic [DEG-1:0] result_q, result_d;
    logic           out_valid_q, out_valid_d;
    logic           div0_q, div0_d;

    logic [DEG-1:0]   op_a, op_b, acc_base, acc_next;
    logic [StepW-1:0] bit_idx;
    logic             step_last, mul_last;
    logic             unused_poly_msb;

    // Leading coefficient of the modulus is implied.
    assign unused_poly_msb = bus.POLY[DEG];

    function automatic logic [DEG-1:0] xt(input logic [DEG-1:0] x, input logic [DEG-1:0] p);
        return {x[DEG-2:0], 1'b0} ^ (x[DEG-1] ? p : '0);
    endfunction

    always_comb begin
        op_a = a_q;
        op_b = b_q;
        if (mode_q == ModeSqr) begin
            op_b = a_q;
        end else if (mode_q == ModeDiv) begin
            // Square-and-multiply by B, then one square, then the final multiply by A.
            op_b = r_q;
            if (mul_q == MulW'(NMulDiv - 1)) begin
                op_a = a_q;
            end else if (!mul_q[0]) begin
                op_a = r_q;
            end else begin
                op_a = b_q;
            end
        end
    end

    assign bit_idx   = StepW'(DEG - 1) - step_q;
    assign acc_base  = (step_q == '0) ? '0 : acc_q;
    assign acc_next  = xt(acc_base, poly_q) ^ (op_b[bit_idx] ? op_a : '0);
    assign step_last = (step_q == StepW'(DEG - 1));
    assign mul_last  = (mode_q != ModeDiv) || (mul_q == MulW'(NMulDiv - 1));

    always_comb begin
        st_d        = st_q;
        mode_d      = mode_q;
        poly_d      = poly_q;
        a_d         = a_q;
        b_d         = b_q;
        r_d         = r_q;
        acc_d       = acc_q;
        step_d      = step_q;
        mul_d       = mul_q;
        result_d    = result_q;
        out_valid_d = 1'b0;
        div0_d      = 1'b0;
        unique case (st_q)
            StIdle: begin
                if (bus.in_valid) begin
                    mode_d = bus.MODE;
                    poly_d = bus.POLY[DEG-1:0];
                    a_d    = bus.IN1;
                    b_d    = bus.IN2;
                    r_d    = bus.IN2;
                    step_d = '0;
                    mul_d  = '0;
                    if (bus.MODE == ModeAdd) begin
                        result_d    = bus.IN1 ^ bus.IN2;
                        out_valid_d = 1'b1;
                    end else begin
                        st_d = StMult;
                    end
                end
            end
            StMult: begin
                acc_d = acc_next;
                if (step_last) begin
                    step_d = '0;
                    if (mul_last) begin
                        result_d    = acc_next;
                        out_valid_d = 1'b1;
                        div0_d      = (mode_q == ModeDiv) && (b_q == '0);
                        mul_d       = '0;
                        st_d        = StIdle;
                    end else begin
                        r_d   = acc_next;
                        mul_d = mul_q + MulW'(1);
                    end
                end else begin
                    step_d = step_q + StepW'(1);
                end
            end
            default: st_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= StIdle;
            mode_q      <= '0;
            poly_q      <= '0;
            a_q         <= '0;
            b_q         <= '0;
            r_q         <= '0;
            acc_q       <= '0;
            step_q      <= '0;
            mul_q       <= '0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
            div0_q      <= 1'b0;
        end else begin
            st_q        <= st_d;
            mode_q      <= mode_d;
            poly_q      <= poly_d;
            a_q         <= a_d;
            b_q         <= b_d;
            r_q         <= r_d;
            acc_q       <= acc_d;
            step_q      <= step_d;
            mul_q       <= mul_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
            div0_q      <= div0_d;
        end
    end

    assign bus.busy      = (st_q == StMult);
    assign bus.out_valid = out_valid_q;
    assign bus.RESULT    = result_q;
    assign bus.DIV0      = div0_q;
endmodule
